// File: rtl/disk_read_responder.sv
// Disk-side responder: one stripe read to the data disks of a 3-disk rotating-parity array, returned as a mem_valid strobe.
// Optional READ_PARITY_EN also enables the parity disk and returns its word on rd_valid_data_P.
module disk_read_responder #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_add,
    input  logic [1:0]        rd_pdisk,
    output logic              rd_ready,
    output logic [2:0]        disk_en,
    output logic [ADDR_W-1:0] disk_add,
    input  logic [DATA_W-1:0] disk0_data,
    input  logic [DATA_W-1:0] disk1_data,
    input  logic [DATA_W-1:0] disk2_data,
    output logic              mem_valid,
    output logic [DATA_W-1:0] rd_valid_data_A,
    output logic [DATA_W-1:0] rd_valid_data_B,
`ifdef READ_PARITY_EN
    output logic [DATA_W-1:0] rd_valid_data_P,
`endif
    output logic [ADDR_W-1:0] mem_add,
    output logic              rd_err
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_add;
    logic [1:0]        lat_pdisk;
    logic [2:0]        en_mask;
    logic [DATA_W-1:0] sel_a, sel_b;

    assign rd_ready = (state == S_IDLE);

`ifdef READ_PARITY_EN
    assign en_mask = 3'b111;
`else
    assign en_mask = ~(3'b001 << rd_pdisk);
`endif

    // A is the lower-indexed data disk, B the higher-indexed one
    assign sel_a = (lat_pdisk == 2'd0) ? disk1_data : disk0_data;
    assign sel_b = (lat_pdisk == 2'd2) ? disk1_data : disk2_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            lat_add         <= '0;
            lat_pdisk       <= '0;
            disk_en         <= '0;
            disk_add        <= '0;
            mem_valid       <= 1'b0;
            rd_valid_data_A <= '0;
            rd_valid_data_B <= '0;
`ifdef READ_PARITY_EN
            rd_valid_data_P <= '0;
`endif
            mem_add         <= '0;
            rd_err          <= 1'b0;
        end else begin
            // Response outputs are strobes: zeroed unless this edge enters RESP/ERR
            disk_en         <= '0;
            mem_valid       <= 1'b0;
            rd_valid_data_A <= '0;
            rd_valid_data_B <= '0;
`ifdef READ_PARITY_EN
            rd_valid_data_P <= '0;
`endif
            mem_add         <= '0;
            rd_err          <= 1'b0;
            case (state)
                S_IDLE: begin
                    disk_add <= '0;
                    if (rd_valid) begin
                        lat_add   <= rd_add;
                        lat_pdisk <= rd_pdisk;
                        if (rd_pdisk == 2'd3) begin
                            state     <= S_ERR;
                            mem_valid <= 1'b1;
                            rd_err    <= 1'b1;
                            mem_add   <= rd_add;
                        end else begin
                            state    <= S_ISSUE;
                            disk_en  <= en_mask;
                            disk_add <= rd_add;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    cnt   <= 4'(RD_LAT);
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state           <= S_RESP;
                        mem_valid       <= 1'b1;
                        rd_valid_data_A <= sel_a;
                        rd_valid_data_B <= sel_b;
`ifdef READ_PARITY_EN
                        rd_valid_data_P <= (lat_pdisk == 2'd0) ? disk0_data :
                                           (lat_pdisk == 2'd1) ? disk1_data : disk2_data;
`endif
                        mem_add         <= lat_add;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    disk_add <= '0;
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
